// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the I/D-cache main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BLK_WORDS = 8;
    localparam int unsigned OFF_W     = $clog2(BLK_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFILL  = 2'd1,
        DFILL  = 2'd2,
        DWRITE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response and memory-side signals of the arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              i_grant;
    logic              d_grant;
    logic              fill_valid;
    logic [OFF_W-1:0]  fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              fill_done;
    logic              d_wr_done;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
        output i_grant, d_grant, fill_valid, fill_word, fill_data, fill_done,
               d_wr_done, mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
        input  i_grant, d_grant, fill_valid, fill_word, fill_data, fill_done,
               d_wr_done, mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_blk_word_counter.sv
// Block word counter: clear, count enable, terminal count at the last word of a block.
module blk_word_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [OFF_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + OFF_W'(1);
        end
    end

    assign tc = (count == OFF_W'(BLK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter between I-cache fills and D-cache fills/write-throughs.
// Define ARB_RR_EN for round-robin on collisions; default is fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            state;
    state_t            state_nx;
    logic              pick_d;
    logic [ADDR_W-2:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              issue_done;
    logic              in_fill;
    logic              issue_en;
    logic              ret_valid;
    logic              ret_done;
    logic [OFF_W-1:0]  issue_cnt;
    logic [OFF_W-1:0]  ret_cnt;
    logic              issue_tc;
    logic              ret_tc;

    assign in_fill   = (state == IFILL) || (state == DFILL);
    assign issue_en  = in_fill && !issue_done;
    assign ret_valid = in_fill && bus.mem_rvalid;
    assign ret_done  = ret_valid && ret_tc;

`ifdef ARB_RR_EN
    // Set when I held the most recent grant; reset value hands the first collision to D.
    logic last_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_i <= 1'b1;
        end else if (state == IDLE && state_nx != IDLE) begin
            last_i <= !pick_d;
        end
    end

    always_comb begin
        pick_d = bus.d_req && (!bus.i_req || last_i);
    end
`else
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nx = bus.d_wr ? DWRITE : DFILL;
                end else if (bus.i_req) begin
                    state_nx = IFILL;
                end
            end
            IFILL, DFILL: begin
                if (ret_done) begin
                    state_nx = IDLE;
                end
            end
            DWRITE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Requester address/data captured at grant so later changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            issue_done <= 1'b0;
        end else if (state == IDLE) begin
            issue_done <= 1'b0;
            if (state_nx != IDLE) begin
                addr_q  <= pick_d ? bus.d_addr[ADDR_W-1:1] : bus.i_addr[ADDR_W-1:1];
                wdata_q <= bus.d_wdata;
            end
        end else if (issue_en && issue_tc) begin
            issue_done <= 1'b1;
        end
    end

    blk_word_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == IDLE),
        .en    (issue_en),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    blk_word_counter u_ret_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == IDLE),
        .en    (ret_valid),
        .count (ret_cnt),
        .tc    (ret_tc)
    );

    // Output decode
    always_comb begin
        bus.i_grant    = (state == IFILL);
        bus.d_grant    = (state == DFILL) || (state == DWRITE);
        bus.mem_en     = issue_en || (state == DWRITE);
        bus.mem_wr     = (state == DWRITE);
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.d_wr_done  = (state == DWRITE);
        bus.fill_valid = ret_valid;
        bus.fill_word  = ret_cnt;
        bus.fill_data  = bus.mem_rdata;
        bus.fill_done  = ret_done;
        if (state == DWRITE) begin
            bus.mem_addr  = {addr_q, 1'b0};
            bus.mem_wdata = wdata_q;
        end else if (issue_en) begin
            bus.mem_addr = {addr_q[ADDR_W-2:OFF_W], issue_cnt, 1'b0};
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model and randomized requests.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 3;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          word;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [15:0] iss_q[$];
    bit          mon_on = 1'b0;
    bit          last_i_m = 1'b1;

    logic [15:0] mem_arr [0:32767];
    logic [15:0] ref_arr [0:32767];
    logic        mem_ready = 1'b0;
    logic        pv [LAT];
    logic [15:0] pd [LAT];
    logic        stray = 1'b0;
    logic [15:0] stray_data = '0;

    function automatic logic [15:0] init_word(int i);
        return 16'(i * 40503 + 5);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Memory: one request per cycle, reads return LAT cycles later, cleared by rst
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32768; i++) mem_arr[i] <= init_word(i);
            mem_ready <= 1'b1;
        end
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= bus.mem_en && !bus.mem_wr;
            pd[0] <= mem_arr[bus.mem_addr[15:1]];
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            if (bus.mem_en && bus.mem_wr) mem_arr[bus.mem_addr[15:1]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rvalid = pv[LAT-1] | stray;
    assign bus.mem_rdata  = pv[LAT-1] ? pd[LAT-1] : (stray ? stray_data : 16'h0000);

    // Monitor: pops an expectation whenever the DUT issues, returns or writes
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (bus.i_grant && bus.d_grant) check("grant_exclusive", 1, 0);
            if (bus.fill_done && !bus.fill_valid) check("done_without_valid", 1, 0);
            if (bus.mem_en && !bus.mem_wr) begin
                if (iss_q.size() == 0) check("issue_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                else check("issue_addr", 32'(bus.mem_addr), 32'(iss_q.pop_front()));
            end
            if (bus.fill_valid || bus.d_wr_done) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", {bus.fill_valid, bus.d_wr_done}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.wr) begin
                        check("wr_kind", {bus.d_wr_done, bus.fill_valid}, 2'b10);
                        check("wr_strobe", {bus.mem_en, bus.mem_wr, bus.d_grant}, 3'b111);
                        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                        check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
                    end else begin
                        check("fill_owner", {bus.i_grant, bus.d_grant, bus.d_wr_done},
                              e.is_d ? 3'b010 : 3'b100);
                        check("fill_word", 32'(bus.fill_word), 32'(e.word));
                        check("fill_data", 32'(bus.fill_data), 32'(e.data));
                        check("fill_done", 32'(bus.fill_done), 32'(e.word == BLK_WORDS - 1));
                    end
                end
            end
        end
    end

    task automatic push_fill(bit is_d, logic [15:0] a);
        logic [15:0] w_addr;
        for (int w = 0; w < BLK_WORDS; w++) begin
            w_addr = (a & 16'hFFF0) + 16'(2 * w);
            iss_q.push_back(w_addr);
            exp_q.push_back('{is_d, 1'b0, w_addr, ref_arr[w_addr[15:1]], w});
        end
    endtask

    task automatic push_write(logic [15:0] a, logic [15:0] d);
        logic [15:0] wa;
        wa = a & 16'hFFFE;
        exp_q.push_back('{1'b1, 1'b1, wa, d, 0});
        ref_arr[wa[15:1]] = d;
    endtask

    task automatic push_d(bit dw, logic [15:0] da, logic [15:0] dd);
        if (dw) push_write(da, dd);
        else push_fill(1'b1, da);
    endtask

    // Idle gap between transactions, optionally with a stray memory return
    task automatic gap(bit with_stray);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stray      = with_stray && (i == 1);
            stray_data = 16'($urandom);
        end
        stray = 1'b0;
        @(negedge clk);
    endtask

    // Issues one request set (called at a negedge with the DUT idle) and waits for completion
    task automatic run_txn(bit ui, bit ud, bit dw, logic [15:0] ia, logic [15:0] da,
                           logic [15:0] dd, int drop_i_after);
        bit d_first;
        bit i_pend;
        bit d_pend;
        int n;
`ifdef ARB_RR_EN
        d_first = ud && (!ui || last_i_m);
`else
        d_first = ud;
`endif
        if (d_first) begin
            push_d(dw, da, dd);
            if (ui) push_fill(1'b0, ia);
        end else begin
            if (ui) push_fill(1'b0, ia);
            if (ud) push_d(dw, da, dd);
        end
        last_i_m = (ui && ud) ? d_first : !ud;
        bus.i_req   = ui;
        bus.i_addr  = ia;
        bus.d_req   = ud;
        bus.d_wr    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
        i_pend = ui;
        d_pend = ud;
        n = 0;
        while ((i_pend || d_pend) && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) check("grant_latency", {bus.i_grant, bus.d_grant}, d_first ? 2'b01 : 2'b10);
            if (drop_i_after > 0 && n == drop_i_after) begin
                bus.i_req  = 1'b0;
                bus.i_addr = 16'($urandom);
            end
            if (bus.fill_done && bus.i_grant) begin
                i_pend     = 1'b0;
                bus.i_req  = 1'b0;
            end
            if ((bus.fill_done && bus.d_grant) || bus.d_wr_done) begin
                d_pend     = 1'b0;
                bus.d_req  = 1'b0;
            end
        end
        if (i_pend || d_pend) check("txn_timeout", 32'(n), 0);
    endtask

    initial begin
        int cnt;
        int n;
        int kind;
        for (int i = 0; i < 32768; i++) ref_arr[i] = init_word(i);
        rst = 1'b1;
        bus.i_req = 1'b1;  bus.i_addr = 16'h0500;
        bus.d_req = 1'b1;  bus.d_wr = 1'b0;  bus.d_addr = 16'h0A00;  bus.d_wdata = '0;

        // Reset with both requests pending: everything stays quiet, D wins first
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", {bus.i_grant, bus.d_grant, bus.mem_en, bus.mem_wr, bus.d_wr_done,
                                    bus.fill_valid, bus.fill_done, 16'(bus.mem_addr), 3'(bus.fill_word)}, 0);
        end
        rst = 1'b0;
        mon_on = 1'b1;
        run_txn(1, 1, 0, 16'h0500, 16'h0A00, 0, 0);
        gap(0);

        run_txn(1, 0, 0, 16'h1236, 0, 0, 0);
        gap(1);
        run_txn(0, 1, 1, 0, 16'h0040, 16'hBEEF, 0);
        gap(0);
        run_txn(0, 1, 1, 0, 16'h1233, 16'hCAFE, 0);
        gap(0);
        run_txn(1, 0, 0, 16'h123C, 0, 0, 0);
        gap(0);
        run_txn(1, 1, 0, 16'h2100, 16'h3208, 0, 0);
        gap(0);
        run_txn(1, 1, 0, 16'h4410, 16'h550E, 0, 0);
        gap(0);
        run_txn(1, 0, 0, 16'h0456, 0, 0, 2);
        gap(1);

        // Reset after three fill returns: no late returns accepted
        mon_on = 1'b0;
        bus.i_req = 1'b1;  bus.i_addr = 16'h2000;
        cnt = 0;
        n = 0;
        while (cnt < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.fill_valid) cnt++;
        end
        check("midreset_returns", 32'(cnt), 3);
        rst = 1'b1;
        bus.i_req = 1'b0;
        @(negedge clk);
        check("midreset_quiet", {bus.i_grant, bus.d_grant, bus.mem_en, bus.fill_valid}, 0);
        rst = 1'b0;
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_stray", {bus.i_grant, bus.d_grant, bus.fill_valid, bus.fill_done}, 0);
        end
        stray = 1'b0;
        last_i_m = 1'b1;
        exp_q.delete();
        iss_q.delete();
        mon_on = 1'b1;
        @(negedge clk);

        run_txn(1, 1, 0, 16'h6000, 16'h7000, 0, 0);
        gap(0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: run_txn(1, 0, 0, 16'($urandom), 0, 0, 0);
                1: run_txn(0, 1, 0, 0, 16'($urandom), 0, 0);
                2: run_txn(0, 1, 1, 0, 16'($urandom), 16'($urandom), 0);
                3: run_txn(1, 1, 0, 16'($urandom), 16'($urandom), 0, 0);
                default: run_txn(1, 1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 0);
            endcase
            gap($urandom_range(0, 1) == 1);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        check("issue_queue_empty", 32'(iss_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
